// File: rtl/multiplier_taint_track_1bit_pkg.sv
// Shared types for the taint-tracking shift-and-add multiplier: FSM state
// encoding and the iteration-counter width helper.
package multiplier_taint_track_1bit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must hold values 0..num_bits.
    function automatic int cnt_width(input int num_bits);
        return $clog2(num_bits + 1);
    endfunction

endpackage

// File: rtl/multiplier_taint_track_1bit.sv
// Sequential unsigned shift-and-add multiplier (one partial product per clock)
// with a 1-bit taint shadow on every datapath and control register.
module multiplier_taint_track_1bit
    import multiplier_taint_track_1bit_pkg::*;
#(
    parameter int NUM_BITS = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [NUM_BITS-1:0]     multiplier,
    input  logic [NUM_BITS-1:0]     multiplicand,
    input  logic                    start_t,
    input  logic                    multiplier_t,
    input  logic                    multiplicand_t,
    output logic [2*NUM_BITS-1:0]   product,
    output logic                    product_t,
    output logic                    done
);

    localparam int                  CW       = cnt_width(NUM_BITS);
    localparam int                  PW       = 2 * NUM_BITS;
    localparam logic [CW-1:0]       LAST_CNT = CW'(NUM_BITS - 1);

    state_e            state_q,     state_d;
    logic [PW-1:0]     acc_a_q,     acc_a_d;
    logic [NUM_BITS-1:0] sh_b_q,    sh_b_d;
    logic [PW-1:0]     p_q,         p_d;
    logic [CW-1:0]     cnt_q,       cnt_d;
    logic [PW-1:0]     product_q,   product_d;
    logic              done_q,      done_d;

    // Taint shadows: a_t covers acc_a, b_t covers sh_b, ctl_t covers state/count.
    logic              a_t_q,       a_t_d;
    logic              b_t_q,       b_t_d;
    logic              ctl_t_q,     ctl_t_d;
    logic              p_t_q,       p_t_d;
    logic              product_t_q, product_t_d;

    // State, datapath and taint registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_a_q     <= {PW{1'b0}};
            sh_b_q      <= {NUM_BITS{1'b0}};
            p_q         <= {PW{1'b0}};
            cnt_q       <= {CW{1'b0}};
            product_q   <= {PW{1'b0}};
            done_q      <= 1'b0;
            a_t_q       <= 1'b0;
            b_t_q       <= 1'b0;
            ctl_t_q     <= 1'b0;
            p_t_q       <= 1'b0;
            product_t_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_a_q     <= acc_a_d;
            sh_b_q      <= sh_b_d;
            p_q         <= p_d;
            cnt_q       <= cnt_d;
            product_q   <= product_d;
            done_q      <= done_d;
            a_t_q       <= a_t_d;
            b_t_q       <= b_t_d;
            ctl_t_q     <= ctl_t_d;
            p_t_q       <= p_t_d;
            product_t_q <= product_t_d;
        end
    end

    // Next-state, datapath step and taint propagation.
    always_comb begin
        state_d     = state_q;
        acc_a_d     = acc_a_q;
        sh_b_d      = sh_b_q;
        p_d         = p_q;
        cnt_d       = cnt_q;
        product_d   = product_q;
        done_d      = 1'b0;
        a_t_d       = a_t_q;
        b_t_d       = b_t_q;
        ctl_t_d     = ctl_t_q;
        p_t_d       = p_t_q;
        product_t_d = product_t_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_a_d = {{NUM_BITS{1'b0}}, multiplicand};
                    sh_b_d  = multiplier;
                    p_d     = {PW{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    ctl_t_d = start_t;
                    a_t_d   = multiplicand_t;
                    b_t_d   = multiplier_t;
                    p_t_d   = 1'b0;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (sh_b_q[0]) begin
                    p_d = p_q + acc_a_q;
                end else begin
                    p_d = p_q;
                end
                acc_a_d = {acc_a_q[PW-2:0], 1'b0};
                sh_b_d  = {1'b0, sh_b_q[NUM_BITS-1:1]};
                cnt_d   = cnt_q + CW'(1);
                // A tainted B bit decides whether the add happens, so b_t alone taints P.
                p_t_d   = p_t_q | (b_t_q & a_t_q) | b_t_q;
                if (cnt_q == LAST_CNT) begin
                    product_d   = p_d;
                    product_t_d = a_t_q | b_t_q | ctl_t_q;
                    done_d      = 1'b1;
                    state_d     = DONE;
                end else begin
                    state_d     = CALC;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign product   = product_q;
    assign product_t = product_t_q;
    assign done      = done_q;

endmodule

// File: tb/tb_multiplier_taint_track_1bit.sv
// Directed self-checking bench for multiplier_taint_track_1bit (NUM_BITS = 7).
module tb_multiplier_taint_track_1bit;

    localparam int N = 7;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   multiplier;
    logic [N-1:0]   multiplicand;
    logic           start_t;
    logic           multiplier_t;
    logic           multiplicand_t;
    logic [2*N-1:0] product;
    logic           product_t;
    logic           done;

    int errors = 0;
    int checks = 0;

    multiplier_taint_track_1bit #(.NUM_BITS(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .multiplier     (multiplier),
        .multiplicand   (multiplicand),
        .start_t        (start_t),
        .multiplier_t   (multiplier_t),
        .multiplicand_t (multiplicand_t),
        .product        (product),
        .product_t      (product_t),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called just after the accepting edge; returns edges until done (0 on timeout).
    task automatic wait_done(output int lat);
        int i;
        lat = 0;
        i   = 0;
        while (lat == 0 && i < 20) begin
            i++;
            @(posedge clk); #1;
            if (done === 1'b1) lat = i;
        end
    endtask

    // Full transaction; operands and taints are scrambled right after accept.
    task automatic run_mul(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic ta, input logic tb, input logic ts,
                           input int exp_p, input logic exp_t);
        int lat;
        multiplicand   = a;
        multiplier     = b;
        multiplicand_t = ta;
        multiplier_t   = tb;
        start_t        = ts;
        start          = 1'b1;
        @(posedge clk); #1;
        start          = 1'b0;
        multiplicand   = a ^ 7'h5A;
        multiplier     = b ^ 7'h33;
        multiplicand_t = ~ta;
        multiplier_t   = ~tb;
        start_t        = ~ts;
        wait_done(lat);
        check({tag, "_lat"}, lat, 7);
        check({tag, "_p"}, product, exp_p);
        check({tag, "_t"}, product_t, exp_t);
        multiplicand_t = 1'b0;
        multiplier_t   = 1'b0;
        start_t        = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        int dcount;
        rst            = 1'b1;
        start          = 1'b0;
        multiplier     = 7'd0;
        multiplicand   = 7'd0;
        start_t        = 1'b0;
        multiplier_t   = 1'b0;
        multiplicand_t = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_product", product, 0);
        check("rst_product_t", product_t, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_mul("m15x15", 7'd15, 7'd15, 1'b0, 1'b0, 1'b0, 225, 1'b0);
        repeat (100) @(posedge clk);
        #1;
        check("hold_p", product, 225);
        check("hold_done", done, 0);

        run_mul("m0x12", 7'd0, 7'd12, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("m0x12_hold", product, 0);
        run_mul("m1x2", 7'd1, 7'd2, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        run_mul("m0x0", 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        run_mul("m92x75", 7'd92, 7'd75, 1'b0, 1'b0, 1'b0, 6900, 1'b0);
        run_mul("m42x78", 7'd42, 7'd78, 1'b0, 1'b0, 1'b0, 3276, 1'b0);
        run_mul("m127x127", 7'd127, 7'd127, 1'b0, 1'b0, 1'b0, 16129, 1'b0);

        run_mul("taint_a", 7'd92, 7'd75, 1'b1, 1'b0, 1'b0, 6900, 1'b1);
        run_mul("taint_none", 7'd92, 7'd75, 1'b0, 1'b0, 1'b0, 6900, 1'b0);
        run_mul("taint_start", 7'd92, 7'd75, 1'b0, 1'b0, 1'b1, 6900, 1'b1);
        run_mul("taint_b", 7'd92, 7'd75, 1'b0, 1'b1, 1'b0, 6900, 1'b1);

        // Reset three edges into CALC clears the registered result.
        multiplicand = 7'd11;
        multiplier   = 7'd13;
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_p", product, 0);
        check("midrst_t", product_t, 0);
        check("midrst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_mul("after_rst", 7'd42, 7'd78, 1'b0, 1'b0, 1'b0, 3276, 1'b0);

        // start held high through CALC/DONE: one result, then a fresh accept.
        multiplicand = 7'd5;
        multiplier   = 7'd6;
        start        = 1'b1;
        @(posedge clk); #1;
        dcount = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dcount++;
            if (i == 7) check("held_p", product, 30);
        end
        check("held_once", dcount, 1);
        multiplicand = 7'd3;
        multiplier   = 7'd4;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        check("reaccept_lat", lat, 7);
        check("reaccept_p", product, 12);
        @(posedge clk); #1;

        // Operands changed during CALC must not affect the result.
        multiplicand = 7'd9;
        multiplier   = 7'd10;
        start        = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
        multiplicand = 7'd127;
        multiplier   = 7'd127;
        wait_done(lat);
        check("chg_lat", lat, 7);
        check("chg_p", product, 90);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
